// File: rtl/sar_pkg.sv
// Shared types and width helpers for the SAR result path.
// Holds the code type, the buffer FSM states and the FIFO width functions.
package sar_pkg;

  localparam int SAR_DATA_W = 12;

  typedef logic [SAR_DATA_W-1:0] sar_code_t;

  typedef enum logic {
    DISABLED = 1'b0,
    ACCUM    = 1'b1
  } sar_buf_state_t;

  // Pointer width for a power-of-two FIFO; a one-entry FIFO still needs one bit.
  function automatic int sar_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // The level counts 0..depth inclusive, so it needs one bit more than the pointer.
  function automatic int sar_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sar_sync_fifo.sv
// Show-ahead synchronous FIFO. Occupancy comes from a registered count, not from
// comparing pointers. A push while full is accepted only if a pop happens in the same cycle.
module sar_sync_fifo
  import sar_pkg::*;
#(
  parameter int W     = SAR_DATA_W,
  parameter int DEPTH = 8,
  localparam int PTR_W = sar_ptr_w(DEPTH),
  localparam int LVL_W = sar_lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The storage array is not reset. Stale contents are never observable
  // because the output is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/sar_result_buffer.sv
// Captures SAR conversion codes on conv_done rising edges, averages 2^AVG_LOG2 codes per result
// and queues the results for a valid/ready consumer. Build option SAR_DROP_CNT_EN adds drop_cnt.
module sar_result_buffer
  import sar_pkg::*;
#(
  parameter int DATA_W     = SAR_DATA_W,
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int LVL_W     = sar_lvl_w(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  bitout,
  input  logic               conv_done,
  input  logic               enable,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  input  logic               clear_ovf,
`ifdef SAR_DROP_CNT_EN
  output logic [7:0]         drop_cnt,
`endif
  output sar_buf_state_t     state_dbg
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  sar_buf_state_t    state_q;
  sar_buf_state_t    state_d;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              conv_d_q;
  logic              sample_evt;
  logic              push;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] result;

  // A conversion counts once, on the first cycle that conv_done is high.
  assign sample_evt = conv_done & ~conv_d_q;
  assign acc_sum    = acc_q + ACC_W'(bitout);
  assign result     = DATA_W'(acc_sum >> AVG_LOG2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= DISABLED;
      acc_q    <= '0;
      cnt_q    <= '0;
      conv_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      conv_d_q <= conv_done;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      DISABLED: begin
        acc_d = '0;
        cnt_d = '0;
        if (enable) state_d = ACCUM;
      end
      ACCUM: begin
        if (!enable) begin
          state_d = DISABLED;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (sample_evt) begin
          if (cnt_q == CNT_LAST) begin
            push  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = DISABLED;
    endcase
  end

  // Stream handshake: m_data is valid whenever m_valid=1 and is held stable until
  // accepted. A transfer occurs on a clk edge with m_valid & m_ready, and the next entry
  // appears on the following cycle. m_valid never depends on m_ready.
  assign pop  = m_valid & m_ready;
  assign drop = push & full & ~pop;

  sar_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (result),
    .rdata (m_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign m_valid   = ~empty;
  assign state_dbg = state_q;

  // A drop in the same cycle as clear_ovf leaves the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

`ifdef SAR_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          drop_cnt <= 8'd0;
    else if (clear_ovf)                  drop_cnt <= drop ? 8'd1 : 8'd0;
    else if (drop && drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sar_result_buffer.sv
// Bench for sar_result_buffer: an averaging build (AVG_LOG2=2) and a pass-through build
// (AVG_LOG2=0) share one stimulus stream, each with its own reference model and scoreboard.
module tb_sar_result_buffer;
  import sar_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] bitout;
  logic        conv_done;
  logic        enable;
  logic        m_ready;
  logic        clear_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LOG2 = (g == 0) ? 2 : 0;
    localparam int N    = 1 << LOG2;

    logic [11:0]    m_data;
    logic           m_valid;
    logic [3:0]     fifo_level;
    logic           overflow;
    sar_buf_state_t state_dbg;
`ifdef SAR_DROP_CNT_EN
    logic [7:0]     drop_cnt;
`endif

    sar_result_buffer #(
      .DATA_W     (12),
      .AVG_LOG2   (LOG2),
      .FIFO_DEPTH (DEPTH)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .bitout     (bitout),
      .conv_done  (conv_done),
      .enable     (enable),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .clear_ovf  (clear_ovf),
`ifdef SAR_DROP_CNT_EN
      .drop_cnt   (drop_cnt),
`endif
      .state_dbg  (state_dbg)
    );

    logic [11:0] exp_q[$];
    int          samples[$];
    int          mdl_level;
    int          mdl_drops;
    bit          mdl_ovf;
    bit          mdl_active;
    bit          prev_cd;

    // Reference model: checks the state reached at the last edge, then predicts the next edge.
    always @(negedge clk) begin : model
      int sum;
      bit push, pop, drop;
      logic [11:0] val;
      if (!reset) begin
        check($sformatf("g%0d_rst_valid", g), m_valid, 0);
        check($sformatf("g%0d_rst_level", g), fifo_level, 0);
        check($sformatf("g%0d_rst_ovf", g), overflow, 0);
        check($sformatf("g%0d_rst_data", g), m_data, 0);
        exp_q.delete();
        samples.delete();
        mdl_level = 0; mdl_drops = 0; mdl_ovf = 0; mdl_active = 0; prev_cd = 0;
      end else begin
        check($sformatf("g%0d_level", g), fifo_level, mdl_level);
        check($sformatf("g%0d_valid", g), m_valid, mdl_level > 0);
        check($sformatf("g%0d_ovf", g), overflow, mdl_ovf);
        check($sformatf("g%0d_state", g), state_dbg, mdl_active ? ACCUM : DISABLED);
`ifdef SAR_DROP_CNT_EN
        check($sformatf("g%0d_drop_cnt", g), drop_cnt, mdl_drops);
`endif
        pop  = (mdl_level > 0) && m_ready;
        push = 0;
        val  = '0;
        if (mdl_active && enable) begin
          if (conv_done && !prev_cd) begin
            samples.push_back(int'(bitout));
            if (samples.size() == N) begin
              sum = 0;
              foreach (samples[i]) sum += samples[i];
              val  = 12'(sum / N);
              push = 1;
              samples.delete();
            end
          end
        end else begin
          samples.delete();
        end
        drop = push && (mdl_level == DEPTH) && !pop;
        if (push && !drop) exp_q.push_back(val);
        mdl_level = mdl_level + ((push && !drop) ? 1 : 0) - (pop ? 1 : 0);
        if (drop) mdl_ovf = 1;
        else if (clear_ovf) mdl_ovf = 0;
        if (clear_ovf) mdl_drops = drop ? 1 : 0;
        else if (drop && mdl_drops < 255) mdl_drops++;
        mdl_active = enable;
        prev_cd    = conv_done;
      end
    end

    // Scoreboard monitor: the head must be visible while valid; a handshake retires it.
    always @(negedge clk) begin : monitor
      if (reset && m_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL g%0d_extra_output: got 0x%0h, expected no output", g, m_data);
        end else begin
          check($sformatf("g%0d_m_data", g), m_data, exp_q[0]);
          if (m_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic conv(input logic [11:0] code, input int hold);
    bitout    = code;
    conv_done = 1'b1;
    repeat (hold) tick();
    conv_done = 1'b0;
    bitout    = 12'($urandom);
    tick();
  endtask

  task automatic pulse_clear();
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
  endtask

  initial begin
    reset = 1'b0; bitout = '0; conv_done = 1'b0; enable = 1'b0;
    m_ready = 1'b0; clear_ovf = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Basic average and latency, then full-scale codes and pass-through codes.
    enable = 1'b1; m_ready = 1'b1;
    tick();
    conv(12'd100, 1); conv(12'd101, 1); conv(12'd102, 1); conv(12'd103, 1);
    repeat (4) conv(12'hFFF, 1);
    conv(12'h000, 1); conv(12'h7FF, 1); conv(12'hFFF, 1); conv(12'h001, 1);
    repeat (3) tick();

    // Held conv_done counts once; single-cycle pulses count too.
    for (int i = 0; i < 4; i++) conv(12'(200 + i), 5);
    for (int i = 0; i < 4; i++) conv(12'(300 + i), 1);
    repeat (3) tick();

    // Overflow: nine results with the consumer stalled, then drain and clear.
    m_ready = 1'b0;
    for (int k = 1; k <= 9; k++) repeat (4) conv(12'(k), 1);
    tick();
    m_ready = 1'b1;
    repeat (12) tick();
    pulse_clear();
    tick();

    // Push and pop on the same edge while full.
    m_ready = 1'b0;
    for (int k = 1; k <= 8; k++) repeat (4) conv(12'(16 + k), 1);
    pulse_clear();
    repeat (3) conv(12'h055, 1);
    m_ready = 1'b1;
    conv(12'h055, 1);
    m_ready = 1'b0;
    repeat (2) tick();
    m_ready = 1'b1;
    repeat (12) tick();
    pulse_clear();

    // Partial average discarded by reset, then by dropping enable.
    conv(12'h123, 1); conv(12'h123, 1);
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    repeat (4) conv(12'h800, 1);
    conv(12'h123, 1); conv(12'h123, 1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    repeat (4) conv(12'h800, 1);
    repeat (4) tick();

    // Randomized traffic with stalls, enable drops and overflow clears.
    for (int c = 0; c < 600; c++) begin
      enable    = ($urandom_range(0, 24) != 0);
      conv_done = ($urandom_range(0, 2) == 0);
      bitout    = 12'($urandom);
      m_ready   = (c % 150 < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
      clear_ovf = ($urandom_range(0, 19) == 0);
      if (c == 400) reset = 1'b0;
      if (c == 402) reset = 1'b1;
      tick();
    end

    // Final drain: every expected result must have been delivered.
    enable = 1'b0; conv_done = 1'b0; clear_ovf = 1'b0; m_ready = 1'b1;
    repeat (20) tick();
    check("g0_drain_empty", g_dut[0].exp_q.size(), 0);
    check("g1_drain_empty", g_dut[1].exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
